pint_frame_ctrl: RTL and testbench

//  Frame controller directly upstream and downstream of the PINT bit-level interface.

---
 rtl/pint_frame_ctrl_pkg.sv | 10 +
 rtl/pint_frame_ctrl_if.sv | 20 ++
 rtl/pint_frame_ctrl_fifo.sv | 37 +++
 rtl/pint_frame_ctrl.sv | 133 +++++++++++++
 tb/tb_pint_frame_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pint_frame_ctrl_pkg.sv
// pint_frame_ctrl_pkg: shared constants, TX state encoding and RX buffer word layout
package pint_frame_ctrl_pkg;
  localparam int DEF_MAX_PAYLOAD = 15;
  localparam int DEF_RX_AW = 4;
  typedef enum logic [2:0] {IDLE, LOAD, KICK, WBUSY, WIDLE} tx_state_t;
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } rx_word_t;
endpackage

// File: rtl/pint_frame_ctrl_if.sv
// pint_frame_ctrl_if: host byte streams (in_* toward PINT, out_* from PINT); master=host, slave=controller
interface pint_frame_ctrl_if;
  logic [7:0] in_data;
  logic       in_cmd_type;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;
  modport master(
    output in_data, in_cmd_type, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );
  modport slave(
    input  in_data, in_cmd_type, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_valid
  );
endinterface

// File: rtl/pint_frame_ctrl_fifo.sv
// pint_frame_ctrl_fifo: first-word-fall-through FIFO (wr_en/wr_data in, rd_en/rd_data out, empty/full flags)
module pint_frame_ctrl_fifo #(
  parameter int W  = 9,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);
  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          we, re;
  assign we      = wr_en & ~full;
  assign re      = rd_en & ~empty;
  assign empty   = cnt == '0;
  assign full    = cnt[AW];
  assign rd_data = mem[rp];
  always_ff @(posedge clk)
    if (we) mem[wp] <= wr_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (we) wp <= wp + 1'b1;
      if (re) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(we) - (AW+1)'(re);
    end
  end
endmodule

// File: rtl/pint_frame_ctrl.sv
// pint_frame_ctrl: host frames <-> PINT strobes (host streams on hs; tx_*/pint_busy/dbg_tx_active/rx_* to PINT; sticky err_* flags)
module pint_frame_ctrl
  import pint_frame_ctrl_pkg::*;
#(
  parameter int MAX_PAYLOAD = DEF_MAX_PAYLOAD,
  parameter int RX_AW       = DEF_RX_AW
) (
  input  logic             clk,
  input  logic             reset,
  pint_frame_ctrl_if.slave hs,
  output logic [7:0]       tx_char,
  output logic             tx_char_latch,
  output logic             tx_req,
  output logic             tx_cmd_type,
  input  logic             pint_busy,
  input  logic             dbg_tx_active,
  input  logic [7:0]       rx_data,
  input  logic             rx_latch,
  input  logic             rx_req,
  output logic             tx_done,
  output logic             err_overlen,
  output logic             err_rx_ovf
);
  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam logic [CW-1:0] MAXP = CW'(MAX_PAYLOAD);
  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic          in_rdy, acc, tx_seen, seen_now;
  logic [7:0]    stg_data;
  logic          stg_full, wr_en, buf_empty, buf_full, pop;
  rx_word_t      wr_word, rd_word;
  assign acc         = hs.in_valid & in_rdy;
  assign seen_now    = tx_seen | dbg_tx_active;
  assign hs.in_ready = in_rdy;
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      in_rdy        <= 1'b0;
      tx_char       <= '0;
      tx_char_latch <= 1'b0;
      tx_req        <= 1'b0;
      tx_cmd_type   <= 1'b0;
      tx_done       <= 1'b0;
      err_overlen   <= 1'b0;
      tx_seen       <= 1'b0;
    end else begin
      tx_char_latch <= 1'b0;
      tx_req        <= 1'b0;
      tx_done       <= 1'b0;
      case (state)
        IDLE:
          if (acc) begin
            tx_char       <= hs.in_data;
            tx_char_latch <= 1'b1;
            tx_cmd_type   <= hs.in_cmd_type;
            cnt           <= CW'(1);
            state         <= hs.in_last ? KICK : LOAD;
            in_rdy        <= ~hs.in_last;
          end else begin
            in_rdy <= 1'b1;
          end
        LOAD:
          if (acc) begin
            if (cnt < MAXP) begin
              tx_char       <= hs.in_data;
              tx_char_latch <= 1'b1;
              cnt           <= cnt + 1'b1;
            end else begin
              err_overlen <= 1'b1;
            end
            if (hs.in_last) begin
              state  <= KICK;
              in_rdy <= 1'b0;
            end
          end
        KICK:
          if (!pint_busy) begin
            tx_req  <= 1'b1;
            tx_seen <= 1'b0;
            state   <= WBUSY;
          end
        WBUSY: begin
          tx_seen <= seen_now;
          if (pint_busy) state <= WIDLE;
        end
        WIDLE: begin
          tx_seen <= seen_now;
          if (!pint_busy) begin
            state   <= seen_now ? IDLE : KICK;
            tx_done <= seen_now;
            in_rdy  <= seen_now;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // buffer writes are registered so the final byte of a frame appears two cycles after rx_req
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_data   <= '0;
      stg_full   <= 1'b0;
      wr_en      <= 1'b0;
      wr_word    <= '0;
      err_rx_ovf <= 1'b0;
    end else begin
      wr_en   <= stg_full & (rx_latch | rx_req);
      wr_word <= {rx_req, stg_data};
      if (rx_latch) begin
        stg_data <= rx_data;
        stg_full <= 1'b1;
      end else if (rx_req) begin
        stg_full <= 1'b0;
      end
      if (wr_en & buf_full) err_rx_ovf <= 1'b1;
    end
  end
  assign pop          = ~buf_empty & hs.out_ready;
  assign hs.out_valid = ~buf_empty;
  assign hs.out_data  = buf_empty ? '0 : rd_word.data;
  assign hs.out_last  = ~buf_empty & rd_word.last;
  pint_frame_ctrl_fifo #(.W($bits(rx_word_t)), .AW(RX_AW)) u_rx_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_word),
    .rd_en   (pop),
    .rd_data (rd_word),
    .empty   (buf_empty),
    .full    (buf_full)
  );
endmodule

// File: tb/tb_pint_frame_ctrl.sv
// tb_pint_frame_ctrl: table-driven and scoreboarded bench for pint_frame_ctrl
module tb_pint_frame_ctrl;
  localparam int MAXP = 15;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_char;
  logic       tx_char_latch, tx_req, tx_cmd_type, tx_done, err_overlen, err_rx_ovf;
  logic       pint_busy = 1'b0;
  logic       dbg_tx_active = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_latch = 1'b0;
  logic       rx_req = 1'b0;
  pint_frame_ctrl_if hs();
  pint_frame_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .hs            (hs),
    .tx_char       (tx_char),
    .tx_char_latch (tx_char_latch),
    .tx_req        (tx_req),
    .tx_cmd_type   (tx_cmd_type),
    .pint_busy     (pint_busy),
    .dbg_tx_active (dbg_tx_active),
    .rx_data       (rx_data),
    .rx_latch      (rx_latch),
    .rx_req        (rx_req),
    .tx_done       (tx_done),
    .err_overlen   (err_overlen),
    .err_rx_ovf    (err_rx_ovf)
  );
  always #5 clk = ~clk;
  typedef struct {
    int         len;
    logic       cmd;
    logic [7:0] base;
    int         exp_lat;
    logic       exp_ovl;
  } tx_vec_t;
  typedef struct {
    int         len;
    logic [7:0] base;
  } rx_vec_t;
  tx_vec_t    tv[4];
  rx_vec_t    rv[3];
  logic [7:0] txq[$];
  logic [8:0] rxq[$];
  int tests = 0;
  int fails = 0;
  int n_lat = 0;
  int n_req = 0;
  int n_done = 0;
  int l0, r0, d0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input int len, input logic cmd, input logic [7:0] base, input logic term);
    int guard;
    for (int i = 0; i < len; i++) begin
      hs.in_valid    = 1'b1;
      hs.in_data     = 8'(base + i * 17);
      hs.in_cmd_type = cmd;
      hs.in_last     = term && (i == len - 1);
      if (i < MAXP) txq.push_back(hs.in_data);
      guard = 0;
      while (hs.in_ready !== 1'b1 && guard < 50) begin
        tick();
        guard++;
      end
      if (guard == 50) check("in_ready_timeout", 32'd0, 32'd1);
      tick();
    end
    hs.in_valid = 1'b0;
    hs.in_last  = 1'b0;
  endtask
  task automatic wait_req(input int prev);
    int guard = 0;
    while (n_req <= prev && guard < 50) begin
      tick();
      guard++;
    end
    if (guard == 50) check("tx_req_timeout", 32'd0, 32'd1);
  endtask
  task automatic complete_tx(input logic act);
    pint_busy     = 1'b1;
    dbg_tx_active = act;
    repeat (3) tick();
    pint_busy     = 1'b0;
    dbg_tx_active = 1'b0;
    repeat (3) tick();
  endtask
  task automatic rx_frame(input int len, input logic [7:0] base, input bit expect_all);
    for (int i = 0; i < len; i++) begin
      rx_latch = 1'b1;
      rx_data  = 8'(base + i * 17);
      if (expect_all) rxq.push_back({i == len - 1, rx_data});
      tick();
      rx_latch = 1'b0;
    end
    rx_req = 1'b1;
    tick();
    rx_req = 1'b0;
  endtask
  always @(negedge clk) begin
    if (tx_char_latch === 1'b1) begin
      n_lat++;
      if (txq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tx_char_unexpected: got %0h expected no latch", tx_char);
      end else begin
        check("tx_char", tx_char, txq.pop_front());
      end
    end
    if (tx_req === 1'b1) begin
      n_req++;
      check("latch_req_excl", tx_char_latch, 1'b0);
    end
    if (tx_done === 1'b1) n_done++;
    if (hs.out_valid === 1'b1 && hs.out_ready === 1'b1) begin
      if (rxq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rx_unexpected: got %0h expected no output", {hs.out_last, hs.out_data});
      end else begin
        check("rx_out", {hs.out_last, hs.out_data}, rxq.pop_front());
      end
    end
  end
  always @(posedge clk)
    assert (!(rx_latch && rx_req)) else $error("rx_latch and rx_req coincide");
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tv[0] = '{3,  1'b1, 8'hA1, 3,  1'b0};
    tv[1] = '{1,  1'b0, 8'h40, 1,  1'b0};
    tv[2] = '{15, 1'b0, 8'h10, 15, 1'b0};
    tv[3] = '{20, 1'b1, 8'h60, 15, 1'b1};
    rv[0] = '{3, 8'h11};
    rv[1] = '{1, 8'h7E};
    rv[2] = '{5, 8'h80};
    hs.in_valid    = 1'b0;
    hs.in_data     = '0;
    hs.in_cmd_type = 1'b0;
    hs.in_last     = 1'b0;
    hs.out_ready   = 1'b1;
    repeat (2) tick();
    check("reset_state", {tx_char, tx_char_latch, tx_req, tx_cmd_type, tx_done, err_overlen,
                          err_rx_ovf, hs.in_ready, hs.out_valid, hs.out_data, hs.out_last}, 32'd0);
    reset = 1'b0;
    tick();
    check("in_ready_after_reset", hs.in_ready, 1'b1);
    foreach (tv[k]) begin
      l0 = n_lat;
      r0 = n_req;
      d0 = n_done;
      send_frame(tv[k].len, tv[k].cmd, tv[k].base, 1'b1);
      wait_req(r0);
      check("tx_latches", n_lat - l0, tv[k].exp_lat);
      check("tx_cmd_type", tx_cmd_type, tv[k].cmd);
      check("err_overlen", err_overlen, tv[k].exp_ovl);
      complete_tx(1'b1);
      check("tx_req_once", n_req - r0, 1);
      check("tx_done_once", n_done - d0, 1);
      check("txq_drained", txq.size(), 0);
    end
    r0 = n_req;
    d0 = n_done;
    pint_busy = 1'b1;
    send_frame(2, 1'b0, 8'h90, 1'b1);
    repeat (5) tick();
    check("kick_hold", n_req - r0, 0);
    check("kick_no_req", tx_req, 1'b0);
    pint_busy = 1'b0;
    tick();
    check("kick_req", tx_req, 1'b1);
    pint_busy = 1'b1;
    repeat (3) tick();
    pint_busy = 1'b0;
    wait_req(r0 + 1);
    check("retry_req", n_req - r0, 2);
    check("retry_no_done", n_done - d0, 0);
    complete_tx(1'b1);
    check("retry_done", n_done - d0, 1);
    foreach (rv[k]) begin
      rx_frame(rv[k].len, rv[k].base, 1'b1);
      repeat (6) tick();
      check("rx_drained", rxq.size(), 0);
    end
    hs.out_ready = 1'b0;
    rx_latch = 1'b1;
    rx_data  = 8'h5A;
    tick();
    rx_latch = 1'b0;
    rx_req   = 1'b1;
    tick();
    rx_req = 1'b0;
    check("rx_lat_1cyc", hs.out_valid, 1'b0);
    tick();
    check("rx_lat_2cyc", {hs.out_valid, hs.out_last, hs.out_data}, {2'b11, 8'h5A});
    rxq.push_back({1'b1, 8'h5A});
    hs.out_ready = 1'b1;
    repeat (3) tick();
    check("rx_lat_drained", rxq.size(), 0);
    check("rx_ovf_clear", err_rx_ovf, 1'b0);
    hs.out_ready = 1'b0;
    rx_frame(17, 8'h03, 1'b0);
    repeat (3) tick();
    check("rx_ovf_set", err_rx_ovf, 1'b1);
    for (int i = 0; i < 16; i++) rxq.push_back({1'b0, 8'(8'h03 + i * 17)});
    hs.out_ready = 1'b1;
    repeat (20) tick();
    check("rx_ovf_drained", rxq.size(), 0);
    check("rx_ovf_empty", hs.out_valid, 1'b0);
    rx_req = 1'b1;
    tick();
    rx_req = 1'b0;
    repeat (4) tick();
    check("rx_zero_byte", hs.out_valid, 1'b0);
    r0 = n_req;
    d0 = n_done;
    send_frame(2, 1'b1, 8'hD1, 1'b0);
    reset = 1'b1;
    tick();
    check("reset_mid_load", {tx_char, tx_char_latch, tx_req, tx_cmd_type, tx_done, err_overlen,
                             err_rx_ovf, hs.in_ready, hs.out_valid, hs.out_data, hs.out_last}, 32'd0);
    reset = 1'b0;
    repeat (5) tick();
    check("reset_no_req", n_req - r0, 0);
    check("reset_txq", txq.size(), 0);
    send_frame(1, 1'b0, 8'h3C, 1'b1);
    wait_req(r0);
    check("post_reset_req", n_req - r0, 1);
    complete_tx(1'b1);
    check("post_reset_done", n_done - d0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
